calc_disp_ctrl: RTL

Sequencing controller for the calculator's two's-complement display path. It debounces the two push buttons and steps through operand A entry, operand B entry and result display. It latches operands from the switches, computes an 8-bit signed sum or difference, and drives the `x`/`enable` inputs of the 4-digit signed display block.

---
 rtl/calc_disp_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/calc_disp_ctrl.sv
// Calculator display sequencer: debounces the next/clear buttons, walks through
// A entry, B entry and result display, and drives the signed display block.
module calc_disp_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       op_sub,
  input  logic       key_next_n,
  input  logic       key_clr_n,
  output logic [7:0] disp_x,
  output logic       disp_en,
  output logic       ovf,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER_A = 2'd1,
    ENTER_B = 2'd2,
    RESULT  = 2'd3
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] key_ev;
  logic       ev_next;
  logic       ev_clr;

  assign key_raw = {key_clr_n, key_next_n};
  assign ev_next = key_ev[0];
  assign ev_clr  = key_ev[1];

  // Bit 0 is the next key, bit 1 the clear key; both use identical conditioning.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic          s1_reg;
      logic          s2_reg;
      logic          deb_reg;
      logic          deb_d_reg;
      logic          ev_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_reg    <= 1'b1;
          s2_reg    <= 1'b1;
          deb_reg   <= 1'b1;
          deb_d_reg <= 1'b1;
          ev_reg    <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= key_raw[gi];
          s2_reg    <= s1_reg;
          deb_d_reg <= deb_reg;
          ev_reg    <= deb_d_reg & ~deb_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign key_ev[gi] = ev_reg;
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] r_reg, r_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] sum, diff;

  assign sum  = a_reg + sw;
  assign diff = a_reg - sw;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    r_next     = r_reg;
    ovf_next   = ovf_reg;
    // Clear has priority over a simultaneous next event.
    if (ev_clr) begin
      state_next = IDLE;
      a_next     = '0;
      r_next     = '0;
      ovf_next   = 1'b0;
    end else if (ev_next) begin
      case (state_reg)
        IDLE:    state_next = ENTER_A;
        ENTER_A: begin
          state_next = ENTER_B;
          a_next     = sw;
        end
        ENTER_B: begin
          state_next = RESULT;
          if (op_sub) begin
            r_next   = diff;
            ovf_next = (a_reg[7] != sw[7]) && (diff[7] != a_reg[7]);
          end else begin
            r_next   = sum;
            ovf_next = (a_reg[7] == sw[7]) && (sum[7] != a_reg[7]);
          end
        end
        RESULT: begin
          state_next = IDLE;
          a_next     = '0;
          r_next     = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      r_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      r_reg     <= r_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Display outputs lag the state register by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_x  <= '0;
      disp_en <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          disp_x  <= '0;
          disp_en <= 1'b0;
          ovf     <= 1'b0;
        end
        ENTER_A, ENTER_B: begin
          disp_x  <= sw;
          disp_en <= 1'b1;
          ovf     <= 1'b0;
        end
        RESULT: begin
          disp_x  <= r_reg;
          disp_en <= 1'b1;
          ovf     <= ovf_reg;
        end
      endcase
    end
  end

  assign state_o = state_reg;

endmodule
